// File: rtl/alu_cmd_queue.sv
// Command FIFO that sits in front of a 4-bit ALU.
// It normalises opcodes and flags divide-by-zero at push time.
module alu_cmd_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic [2:0] in_op,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_a,
    output logic [3:0] out_b,
    output logic [2:0] out_op,
    output logic       out_div0,
    output logic [4:0] count,
    output logic       overflow,
    input  logic       clear
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  Full = 5'(DEPTH);

    // Entry layout: {op[2:0], a[3:0], b[3:0], div0}
    logic [11:0]     mem [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]      count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            push, pop;
    logic [2:0]      op_norm;
    logic            div0_in;
    logic [11:0]     head;
    logic            unused_ena;

    assign unused_ena = ena;

    assign in_ready  = (count_q != Full);
    assign out_valid = (count_q != 5'd0);
    assign count     = count_q;
    assign overflow  = overflow_q;

    assign op_norm = (in_op[2:1] == 2'b11) ? 3'b000 : in_op;
    assign div0_in = (in_op == 3'b010) && (in_b == 4'b0000);

    assign push = in_valid && in_ready && !clear;
    assign pop  = out_valid && out_ready && !clear;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = 5'd0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + 5'd1;
                2'b01:   count_d = count_q - 5'd1;
                default: count_d = count_q;
            endcase
            if (in_valid && !in_ready) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 5'd0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; empty-queue outputs are masked instead.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {op_norm, in_a, in_b, div0_in};
    end

    assign head     = out_valid ? mem[rd_ptr_q] : 12'd0;
    assign out_op   = head[11:9];
    assign out_a    = head[8:5];
    assign out_b    = head[4:1];
    assign out_div0 = head[0];

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue: directed vector table, corner sequences,
// then randomised traffic against a queue-based reference model.
module tb_alu_cmd_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a, in_b;
    logic [2:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_a, out_b;
    logic [2:0] out_op;
    logic       out_div0;
    logic [4:0] count;
    logic       overflow;
    logic       clear;

    alu_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_op    (in_op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_op   (out_op),
        .out_div0 (out_div0),
        .count    (count),
        .overflow (overflow),
        .clear    (clear)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: list of {op, a, b, div0} plus sticky overflow flag.
    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       div0;
    } entry_t;

    entry_t m_q[$];
    logic   m_ovf = 1'b0;

    typedef struct {
        logic       v;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       rdy;
        logic       clr;
        int         e_cnt;
        logic       e_val;
        logic [3:0] e_a;
        logic [3:0] e_b;
        logic [2:0] e_op;
        logic       e_div0;
        logic       e_ovf;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clock();
        int  sz;
        bit  do_pop, do_push;
        entry_t e;
        sz = m_q.size();
        if (clear) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            do_pop  = (sz > 0) && out_ready;
            do_push = in_valid && (sz < DEPTH);
            if (in_valid && sz == DEPTH) m_ovf = 1'b1;
            e.op   = (in_op >= 3'd6) ? 3'd0 : in_op;
            e.a    = in_a;
            e.b    = in_b;
            e.div0 = (in_op == 3'd2) && (in_b == 4'd0);
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back(e);
        end
    endtask

    task automatic compare_model(input string tag);
        entry_t h;
        h = (m_q.size() > 0) ? m_q[0] : '0;
        check({tag, ".count"},     int'(count),     m_q.size());
        check({tag, ".out_valid"}, int'(out_valid), int'(m_q.size() > 0));
        check({tag, ".in_ready"},  int'(in_ready),  int'(m_q.size() < DEPTH));
        check({tag, ".overflow"},  int'(overflow),  int'(m_ovf));
        check({tag, ".out_a"},     int'(out_a),     int'(h.a));
        check({tag, ".out_b"},     int'(out_b),     int'(h.b));
        check({tag, ".out_op"},    int'(out_op),    int'(h.op));
        check({tag, ".out_div0"},  int'(out_div0),  int'(h.div0));
    endtask

    // Clock one edge, advance the model, then compare 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        compare_model(tag);
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic rdy, input logic clr);
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = rdy;
        clear     = clr;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        m_q.delete();
        m_ovf = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[10];

    initial begin
        ena = 1'b1;
        // Push 5 with out_ready low, then drain, then clear.
        vecs[0] = '{1, 3'd0, 4'd3, 4'd4, 0, 0, 1, 1, 4'd3, 4'd4, 3'd0, 0, 0};
        vecs[1] = '{1, 3'd1, 4'd5, 4'd2, 0, 0, 2, 1, 4'd3, 4'd4, 3'd0, 0, 0};
        vecs[2] = '{1, 3'd2, 4'd9, 4'd0, 0, 0, 3, 1, 4'd3, 4'd4, 3'd0, 0, 0};
        vecs[3] = '{1, 3'd7, 4'd2, 4'd1, 0, 0, 4, 1, 4'd3, 4'd4, 3'd0, 0, 0};
        vecs[4] = '{1, 3'd3, 4'd1, 4'd1, 0, 0, 4, 1, 4'd3, 4'd4, 3'd0, 0, 1};
        vecs[5] = '{0, 3'd0, 4'd0, 4'd0, 1, 0, 3, 1, 4'd5, 4'd2, 3'd1, 0, 1};
        vecs[6] = '{0, 3'd0, 4'd0, 4'd0, 1, 0, 2, 1, 4'd9, 4'd0, 3'd2, 1, 1};
        vecs[7] = '{0, 3'd0, 4'd0, 4'd0, 1, 0, 1, 1, 4'd2, 4'd1, 3'd0, 0, 1};
        vecs[8] = '{0, 3'd0, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0, 4'd0, 3'd0, 0, 1};
        vecs[9] = '{1, 3'd4, 4'd7, 4'd7, 0, 1, 0, 0, 4'd0, 4'd0, 3'd0, 0, 0};

        // Asynchronous reset value, checked before any clock edge.
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        #2;
        check("reset.count",     int'(count),     0);
        check("reset.out_valid", int'(out_valid), 0);
        check("reset.in_ready",  int'(in_ready),  1);
        check("reset.overflow",  int'(overflow),  0);
        check("reset.out_a",     int'(out_a),     0);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rdy, vecs[i].clr);
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d.tcount", i), int'(count),    vecs[i].e_cnt);
            check($sformatf("vec%0d.tvalid", i), int'(out_valid), int'(vecs[i].e_val));
            check($sformatf("vec%0d.tready", i), int'(in_ready), int'(vecs[i].e_cnt != DEPTH));
            check($sformatf("vec%0d.ta", i),     int'(out_a),    int'(vecs[i].e_a));
            check($sformatf("vec%0d.tb", i),     int'(out_b),    int'(vecs[i].e_b));
            check($sformatf("vec%0d.top", i),    int'(out_op),   int'(vecs[i].e_op));
            check($sformatf("vec%0d.tdiv0", i),  int'(out_div0), int'(vecs[i].e_div0));
            check($sformatf("vec%0d.tovf", i),   int'(overflow), int'(vecs[i].e_ovf));
        end

        // Fill, then push+pop for 8 cycles across pointer wrap.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'(i), 4'(i + 1), 4'(i + 8), 1'b0, 1'b0);
            step("fill");
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i % 6), 4'(i + 5), 4'(15 - i), 1'b1, 1'b0);
            step("wrap");
            check("wrap.max", int'(count <= 5'd4), 1);
        end

        // Three entries then clear with in_valid high.
        drive(1'b0, 3'd0, 4'd0, 4'd0, 1'b1, 1'b1);
        step("preclr");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd5, 4'(i), 4'(i), 1'b0, 1'b0);
            step("clr_fill");
        end
        check("clr_fill.count", int'(count), 3);
        drive(1'b1, 3'd1, 4'd6, 4'd6, 1'b0, 1'b1);
        step("clr");
        check("clr.count", int'(count), 0);
        check("clr.valid", int'(out_valid), 0);

        // Two entries, then reset pulse between edges.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'd0, 4'(i + 1), 4'd1, 1'b0, 1'b0);
            step("ar_fill");
        end
        drive(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.count", int'(count), 0);
        check("arst.valid", int'(out_valid), 0);
        check("arst.ready", int'(in_ready), 1);
        #2;
        rst_n = 1'b1;
        m_q.delete();
        m_ovf = 1'b0;
        drive(1'b1, 3'd4, 4'd12, 4'd10, 1'b0, 1'b0);
        step("post_arst");
        check("post_arst.a", int'(out_a), 12);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] rb;
            rb = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            drive(1'($urandom_range(0, 99) < 60), 3'($urandom), 4'($urandom), rb,
                  1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 63) == 0));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of command entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; clears all state.
REQ-004 ena  input  1  high = design powered; SHALL have no functional effect.
REQ-005 in_valid  input  1  producer presents a command this cycle.
REQ-006 in_ready  output  1  queue can accept a command this cycle.
REQ-007 in_a  input  4  operand A.
REQ-008 in_b  input  4  operand B.
REQ-009 in_op  input  3  ALU opcode: 000 add, 001 sub, 010 div, 011 mul, 100 and, 101 or, 110/111 treated as add.
REQ-010 out_valid  output  1  head command presented to the downstream 4-bit ALU.
REQ-011 out_ready  input  1  ALU consumes the head command this cycle.
REQ-012 out_a / out_b  output  4 each  head operands.
REQ-013 out_op  output  3  head opcode, 110/111 normalised to 000.
REQ-014 out_div0  output  1  head is a divide with B = 0.
REQ-015 count  output  5  entries held, 0..DEPTH.
REQ-016 overflow  output  1  sticky: push attempted while full.
REQ-017 clear  input  1  synchronous flush of all entries.

Function
REQ-018 Push SHALL occur when in_valid && in_ready; the entry {op, a, b, div0} SHALL be written at the write pointer on that edge.
REQ-019 in_ready SHALL equal (count != DEPTH), combinationally from registered state only.
REQ-020 Pop SHALL occur when out_valid && out_ready; the read pointer SHALL advance on that edge.
REQ-021 out_valid SHALL equal (count != 0); out_a/out_b/out_op/out_div0 SHALL reflect the head entry and SHALL be 0 when empty.
REQ-022 Latency: a command pushed into an empty queue SHALL appear on out_* in the next cycle (one-cycle, no bypass).
REQ-023 Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-024 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and move both pointers.
REQ-025 Push and pop same cycle when full: pop occurs, push rejected (in_ready low), count becomes DEPTH-1.
REQ-026 Push and pop same cycle when empty: push only (out_valid low), count becomes 1.
REQ-027 in_valid high while full SHALL not modify storage and SHALL set overflow; overflow SHALL stay set until reset or clear.
REQ-028 div0 SHALL be computed at push as (in_op == 010) && (in_b == 0000); opcode normalisation SHALL also occur at push.
REQ-029 clear high SHALL zero both pointers, count and overflow on that edge, taking priority over push and pop that cycle.
REQ-030 Storage contents SHALL not require reset; only pointers, count and overflow are reset.
REQ-031 out_* SHALL remain stable while out_valid && !out_ready.

Reset
REQ-032 rst_n low SHALL immediately drive count 0, out_valid 0, in_ready 1, overflow 0, out_* 0, independent of clk.
REQ-033 Reset asserted mid-operation SHALL discard all queued commands; after release the first push SHALL be the first popped.
REQ-034 Release of rst_n SHALL be synchronised externally; the block performs no push or pop on the release edge unless handshakes are valid.

Verification
REQ-035 Reset, push {op 000, a 3, b 4} with out_ready 0 -> next cycle out_valid 1, out_a 3, out_b 4, out_op 000, count 1.
REQ-036 Push 5 commands back-to-back, out_ready 0, DEPTH 4 -> count 4, in_ready 0 after 4th, overflow 1, 5th command never appears.
REQ-037 Fill 4, then out_ready 1 and in_valid 1 for 8 cycles -> pop order matches push order across pointer wrap, count never exceeds 4.
REQ-038 Push {op 010, a 9, b 0} then {op 111, a 2, b 1} -> head out_div0 1; second head out_op 000, out_div0 0.
REQ-039 Queue holding 3 entries, assert clear with in_valid 1 -> count 0, overflow 0, out_valid 0 next cycle.
REQ-040 Queue holding 2 entries, pulse rst_n low between clock edges -> count 0 and out_valid 0 before next clk edge.
